decode_hazard_ctrl: RTL and testbench

Front-end controller for the RV32IM pipeline's decode stage. Owns the IF/ID pipeline register that feeds the immediate sign-extension unit and the decoder. Sequences stalls for load-use hazards and multi-cycle M-extension operations, and flushes on taken branches and jumps. Counts stall and flush cycles for performance debug.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 25 ++
 rtl/decode_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32IM shared opcodes, NOP encoding and decode-stage FSM states
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL_LD = 2'd1,
    ST_HOLD_DIV = 2'd2,
    ST_FLUSH    = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between ID source registers and EX load target
module hazard_detect
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       id_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard_o
);

  logic uses_rs1;
  logic uses_rs2;

  // Decode which source fields are real registers, then compare against the load destination
  always_comb begin
    uses_rs1 = !((opcode_i == OPC_LUI) || (opcode_i == OPC_AUIPC) || (opcode_i == OPC_JAL));
    uses_rs2 = (opcode_i == OPC_OP) || (opcode_i == OPC_STORE) || (opcode_i == OPC_BRANCH);
    hazard_o = id_valid_i && ex_memread_i && (ex_rd_i != 5'd0) &&
               ((uses_rs1 && (ex_rd_i == rs1_i)) || (uses_rs2 && (ex_rd_i == rs2_i)));
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - IF/ID register with load-use, divider-hold and redirect-flush sequencing
module decode_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP   = NOP_INSTR,
  parameter int          CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      IF_INSTRUCTION,
  input  logic [31:0]      IF_PC,
  input  logic             IF_VALID,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_RD,
  input  logic             DIV_BUSY,
  input  logic             BRANCH_TAKEN,
  output logic [31:0]      ID_INSTRUCTION,
  output logic [31:0]      ID_PC,
  output logic             ID_VALID,
  output logic             PC_WRITE_EN,
  output logic             BUBBLE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  hz_state_e        state_q, state_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic pc_we;
  logic bubble;
  logic load_id;
  logic kill_id;

  hazard_detect u_hazard_detect (
    .opcode_i     (id_instr_q[6:0]),
    .rs1_i        (id_instr_q[19:15]),
    .rs2_i        (id_instr_q[24:20]),
    .id_valid_i   (id_valid_q),
    .ex_memread_i (EX_MEMREAD),
    .ex_rd_i      (EX_RD),
    .hazard_o     (hazard)
  );

  // Per-cycle priority: redirect > divider hold > load-use stall > flush-slot kill > advance
  always_comb begin
    pc_we   = 1'b1;
    bubble  = 1'b0;
    load_id = 1'b1;
    kill_id = 1'b0;
    state_d = ST_RUN;
    if (BRANCH_TAKEN) begin
      bubble  = 1'b1;
      kill_id = 1'b1;
      state_d = ST_FLUSH;
    end else if (DIV_BUSY) begin
      pc_we   = 1'b0;
      load_id = 1'b0;
      state_d = ST_HOLD_DIV;
    end else if (hazard && (state_q != ST_STALL_LD)) begin
      // the instruction after a load-use stall must advance, so a stall is never longer than one cycle
      pc_we   = 1'b0;
      bubble  = 1'b1;
      load_id = 1'b0;
      state_d = ST_STALL_LD;
    end else if (state_q == ST_FLUSH) begin
      // fetch has one cycle of latency, so this slot still carries the wrong-path instruction
      kill_id = 1'b1;
    end
  end

  // IF/ID next value and counter next values
  always_comb begin
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_id) begin
      id_valid_d = IF_VALID && !kill_id;
      id_instr_d = (IF_VALID && !kill_id) ? IF_INSTRUCTION : NOP;
      id_pc_d    = IF_PC;
    end
    if (!pc_we) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (BRANCH_TAKEN) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, pipeline register and counters
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_RUN;
      id_instr_q  <= NOP;
      id_pc_q     <= 32'd0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Pipeline controls are forced safe (PC frozen, bubble inserted) while reset is asserted
  always_comb begin
    PC_WRITE_EN = RESET_N && pc_we;
    BUBBLE      = !RESET_N || bubble;
  end

  assign ID_INSTRUCTION = id_instr_q;
  assign ID_PC          = id_pc_q;
  assign ID_VALID       = id_valid_q;
  assign STALL_CNT      = stall_cnt_q;
  assign FLUSH_CNT      = flush_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb/tb_decode_hazard_ctrl.sv - scoreboard bench for decode_hazard_ctrl
module tb_decode_hazard_ctrl;

  localparam logic [31:0] NOP_I = 32'h00000013;
  localparam logic [31:0] I0    = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] I1    = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] I2    = 32'h00300193;  // addi x3,x0,3
  localparam logic [31:0] ADD   = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LUI5  = 32'h000282B7;  // lui x5 with rs1 field = 5

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IF_INSTRUCTION, IF_PC;
  logic        IF_VALID, EX_MEMREAD, DIV_BUSY, BRANCH_TAKEN;
  logic [4:0]  EX_RD;
  logic [31:0] ID_INSTRUCTION, ID_PC;
  logic        ID_VALID, PC_WRITE_EN, BUBBLE;
  logic [31:0] STALL_CNT, FLUSH_CNT;

  typedef struct packed {
    logic        we;
    logic        bub;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  decode_hazard_ctrl #(.NOP(32'h00000013), .CNT_W(32)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .IF_INSTRUCTION (IF_INSTRUCTION),
    .IF_PC          (IF_PC),
    .IF_VALID       (IF_VALID),
    .EX_MEMREAD     (EX_MEMREAD),
    .EX_RD          (EX_RD),
    .DIV_BUSY       (DIV_BUSY),
    .BRANCH_TAKEN   (BRANCH_TAKEN),
    .ID_INSTRUCTION (ID_INSTRUCTION),
    .ID_PC          (ID_PC),
    .ID_VALID       (ID_VALID),
    .PC_WRITE_EN    (PC_WRITE_EN),
    .BUBBLE         (BUBBLE),
    .STALL_CNT      (STALL_CNT),
    .FLUSH_CNT      (FLUSH_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag,
                      input logic [31:0] instr, input logic [31:0] pc, input logic iv,
                      input logic mr, input logic [4:0] rd, input logic div, input logic br,
                      input logic ewe, input logic ebub,
                      input logic [31:0] einstr, input logic [31:0] epc, input logic evalid);
    exp_t e;
    IF_INSTRUCTION = instr;
    IF_PC          = pc;
    IF_VALID       = iv;
    EX_MEMREAD     = mr;
    EX_RD          = rd;
    DIV_BUSY       = div;
    BRANCH_TAKEN   = br;
    exp_q.push_back('{we: ewe, bub: ebub, instr: einstr, pc: epc, valid: evalid});
    #2;
    e = exp_q[0];
    chk({tag, ".pc_we"}, {31'd0, PC_WRITE_EN}, {31'd0, e.we});
    chk({tag, ".bubble"}, {31'd0, BUBBLE}, {31'd0, e.bub});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".id_instr"}, ID_INSTRUCTION, e.instr);
    chk({tag, ".id_valid"}, {31'd0, ID_VALID}, {31'd0, e.valid});
    if (e.valid) chk({tag, ".id_pc"}, ID_PC, e.pc);
    @(negedge CLK);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pc_we"}, {31'd0, PC_WRITE_EN}, 32'd0);
    chk({tag, ".bubble"}, {31'd0, BUBBLE}, 32'd1);
    chk({tag, ".id_instr"}, ID_INSTRUCTION, NOP_I);
    chk({tag, ".id_pc"}, ID_PC, 32'd0);
    chk({tag, ".id_valid"}, {31'd0, ID_VALID}, 32'd0);
    chk({tag, ".stall_cnt"}, STALL_CNT, 32'd0);
    chk({tag, ".flush_cnt"}, FLUSH_CNT, 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    IF_INSTRUCTION = 32'd0; IF_PC = 32'd0; IF_VALID = 1'b0;
    EX_MEMREAD = 1'b0; EX_RD = 5'd0; DIV_BUSY = 1'b0; BRANCH_TAKEN = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("rst0");
    RESET_N = 1'b1;

    // plain streaming
    step("s0", I0, 32'h0, 1, 0, 0, 0, 0, 1, 0, I0, 32'h0, 1);
    step("s1", I1, 32'h4, 1, 0, 0, 0, 0, 1, 0, I1, 32'h4, 1);
    step("s2", I2, 32'h8, 1, 0, 0, 0, 0, 1, 0, I2, 32'h8, 1);

    // load-use on rs1: one stall, then advance although the load is still in EX
    step("lu_ld", ADD, 32'hC, 1, 0, 0, 0, 0, 1, 0, ADD, 32'hC, 1);
    step("lu_st", I0, 32'h10, 1, 1, 5'd1, 0, 0, 0, 1, ADD, 32'hC, 1);
    step("lu_go", I0, 32'h10, 1, 1, 5'd1, 0, 0, 1, 0, I0, 32'h10, 1);
    chk("lu_cnt", STALL_CNT, 32'd1);

    // EX_RD=0 never hazards; lui does not read rs1
    step("rd0", LUI5, 32'h14, 1, 1, 5'd0, 0, 0, 1, 0, LUI5, 32'h14, 1);
    step("lui", I1, 32'h18, 1, 1, 5'd5, 0, 0, 1, 0, I1, 32'h18, 1);

    // load-use on rs2
    step("r2_ld", ADD, 32'h1C, 1, 0, 0, 0, 0, 1, 0, ADD, 32'h1C, 1);
    step("r2_st", I2, 32'h20, 1, 1, 5'd2, 0, 0, 0, 1, ADD, 32'h1C, 1);
    step("r2_go", I2, 32'h20, 1, 0, 5'd0, 0, 0, 1, 0, I2, 32'h20, 1);
    chk("r2_cnt", STALL_CNT, 32'd2);

    // invalid fetch loads a NOP
    step("ivl", I0, 32'h24, 0, 0, 0, 0, 0, 1, 0, NOP_I, 32'h24, 0);
    step("ivl2", I1, 32'h28, 1, 0, 0, 0, 0, 1, 0, I1, 32'h28, 1);

    // taken redirect: two killed slots, third fetch valid
    step("br", I2, 32'h2C, 1, 0, 0, 0, 1, 1, 1, NOP_I, 32'h2C, 0);
    step("br_fl", I0, 32'h30, 1, 0, 0, 0, 0, 1, 0, NOP_I, 32'h30, 0);
    step("br_ok", I1, 32'h100, 1, 0, 0, 0, 0, 1, 0, I1, 32'h100, 1);
    chk("br_cnt", FLUSH_CNT, 32'd1);

    // redirect beats load-use
    step("bh_ld", ADD, 32'h104, 1, 0, 0, 0, 0, 1, 0, ADD, 32'h104, 1);
    step("bh_br", I1, 32'h108, 1, 1, 5'd1, 0, 1, 1, 1, NOP_I, 32'h108, 0);
    step("bh_fl", I2, 32'h10C, 1, 1, 5'd1, 0, 0, 1, 0, NOP_I, 32'h10C, 0);
    step("bh_ok", I0, 32'h200, 1, 0, 0, 0, 0, 1, 0, I0, 32'h200, 1);
    chk("bh_scnt", STALL_CNT, 32'd2);
    chk("bh_fcnt", FLUSH_CNT, 32'd2);

    // 33-cycle divider hold
    for (int i = 0; i < 33; i++)
      step("div", I1, 32'h204, 1, 0, 0, 1, 0, 0, 0, I0, 32'h200, 1);
    step("div_go", I1, 32'h204, 1, 0, 0, 0, 0, 1, 0, I1, 32'h204, 1);
    chk("div_cnt", STALL_CNT, 32'd35);

    // reset while in STALL_LD
    step("rs_ld", ADD, 32'h300, 1, 0, 0, 0, 0, 1, 0, ADD, 32'h300, 1);
    step("rs_st", I0, 32'h304, 1, 1, 5'd1, 0, 0, 0, 1, ADD, 32'h300, 1);
    RESET_N = 1'b0;
    #1;
    check_reset("rst_ld");
    @(posedge CLK);
    #1;
    check_reset("rst_ld_hold");
    @(negedge CLK);
    RESET_N = 1'b1;
    step("ar_ld", ADD, 32'h0, 1, 0, 0, 0, 0, 1, 0, ADD, 32'h0, 1);
    step("ar_st", I0, 32'h4, 1, 1, 5'd1, 0, 0, 0, 1, ADD, 32'h0, 1);
    step("ar_go", I0, 32'h4, 1, 0, 0, 0, 0, 1, 0, I0, 32'h4, 1);
    chk("ar_cnt", STALL_CNT, 32'd1);

    // reset while in FLUSH
    step("rf_br", I1, 32'h8, 1, 0, 0, 0, 1, 1, 1, NOP_I, 32'h8, 0);
    RESET_N = 1'b0;
    #1;
    check_reset("rst_fl");
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    step("af_run", I2, 32'h40, 1, 0, 0, 0, 0, 1, 0, I2, 32'h40, 1);
    chk("af_fcnt", FLUSH_CNT, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
